// File: rtl/jacobi_pkg.sv
// Shared types and default sizes for the Jacobi datapath buffer controllers.
package jacobi_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_MEM_SIZE   = 128;
  localparam int DEF_DATA_WIDTH = 20;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    UNLOAD
  } buf_ctrl_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry fall-through valid/ready FIFO carrying {last, data} from buffer reads
// to the unload stream; an empty FIFO forwards the incoming word in the same cycle.
module rd_skid_fifo #(
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic                  push_last,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [1:0]            level,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic                  pop_last,
  output logic [DATA_WIDTH-1:0] pop_data
);

  localparam int EW = DATA_WIDTH + 1;

  logic [EW-1:0] ent_q [2];
  logic [EW-1:0] ent_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          bypass, pop, pop_mem, store;
  logic [EW-1:0] head;

  always_comb begin
    bypass    = (count_q == 2'd0) && push_valid;
    pop_valid = (count_q != 2'd0) || push_valid;
    if (count_q != 2'd0)  head = ent_q[rd_ptr_q];
    else if (push_valid)  head = {push_last, push_data};
    else                  head = '0;
    pop     = pop_valid && pop_ready;
    pop_mem = pop && (count_q != 2'd0);
    // A word forwarded straight through and consumed never touches storage.
    store   = push_valid && !(bypass && pop);
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store) begin
      ent_d[wr_ptr_q] = {push_last, push_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_mem) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, store} - {1'b0, pop_mem};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign level              = count_q;
  assign {pop_last, pop_data} = head;

endmodule

// File: rtl/jacobi_buf_ctrl.sv
// Load / engine-handoff / unload sequencer for one dual-interface Jacobi matrix buffer.
// Optional WAIT-cycle counter output eng_cycles: define JACOBI_BUF_CTRL_PERF_CNT_EN.
module jacobi_buf_ctrl
  import jacobi_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  if_select,
  output logic                  mem_en_a,
  output logic                  mem_we_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_din_a,
  input  logic [DATA_WIDTH-1:0] mem_dout_a,
  output logic                  eng_start,
  output logic [ADDR_WIDTH:0]   eng_len,
  input  logic                  eng_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  ovf
`ifdef JACOBI_BUF_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           eng_cycles
`endif
);

  localparam int            CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MEM_SIZE - 1);

  buf_ctrl_state_t state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            if_select_q, if_select_d;
  logic            ovf_q, ovf_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_pend_last_q, rd_pend_last_d;
  logic            rd_issue;
  logic [1:0]      fifo_level;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    len_d          = len_q;
    rd_cnt_d       = rd_cnt_q;
    if_select_d    = if_select_q;
    ovf_d          = ovf_q;
    rd_pend_last_d = rd_pend_last_q;
    rd_issue       = 1'b0;
    in_ready       = 1'b0;
    eng_start      = 1'b0;
    mem_en_a       = 1'b0;
    mem_we_a       = 1'b0;
    mem_addr_a     = '0;
    mem_din_a      = '0;
    unique case (state_q)
      LOAD: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          mem_en_a   = 1'b1;
          mem_we_a   = 1'b1;
          mem_addr_a = wr_cnt_q[ADDR_WIDTH-1:0];
          mem_din_a  = in_data;
          wr_cnt_d   = wr_cnt_q + ONE;
          if (in_last || wr_cnt_q == LAST_IDX) begin
            state_d     = START;
            len_d       = wr_cnt_q + ONE;
            if_select_d = 1'b1;
            if (!in_last) ovf_d = 1'b1;
          end
        end
      end
      START: begin
        eng_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          if_select_d = 1'b0;
          state_d     = UNLOAD;
        end
      end
      UNLOAD: begin
        // Reads in flight count against FIFO space so a stalled sink never overflows it.
        rd_issue = (rd_cnt_q < len_q) && ((fifo_level + {1'b0, rd_pend_q}) < 2'd2);
        if (rd_issue) begin
          mem_en_a       = 1'b1;
          mem_addr_a     = rd_cnt_q[ADDR_WIDTH-1:0];
          rd_cnt_d       = rd_cnt_q + ONE;
          rd_pend_last_d = (rd_cnt_q == len_q - ONE);
        end
        if (out_valid && out_ready && out_last) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
    rd_pend_d = rd_issue;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD;
      wr_cnt_q       <= '0;
      len_q          <= '0;
      rd_cnt_q       <= '0;
      if_select_q    <= 1'b0;
      ovf_q          <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      len_q          <= len_d;
      rd_cnt_q       <= rd_cnt_d;
      if_select_q    <= if_select_d;
      ovf_q          <= ovf_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
    end
  end

  rd_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_valid(rd_pend_q),
    .push_last (rd_pend_last_q),
    .push_data (mem_dout_a),
    .level     (fifo_level),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_last  (out_last),
    .pop_data  (out_data)
  );

  assign if_select = if_select_q;
  assign eng_len   = len_q;
  assign ovf       = ovf_q;
  assign busy      = !((state_q == LOAD) && (wr_cnt_q == '0));

`ifdef JACOBI_BUF_CTRL_PERF_CNT_EN
  logic [31:0] eng_cycles_q, eng_cycles_d;

  always_comb begin
    eng_cycles_d = eng_cycles_q;
    if (state_q == START) eng_cycles_d = '0;
    else if (state_q == WAIT && eng_cycles_q != '1) eng_cycles_d = eng_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) eng_cycles_q <= '0;
    else     eng_cycles_q <= eng_cycles_d;
  end

  assign eng_cycles = eng_cycles_q;
`endif

endmodule

// File: tb/tb_jacobi_buf_ctrl.sv
// Directed bench for jacobi_buf_ctrl: a cycle table for one 4-word frame plus
// hand sequences for stalls, overflow, ignored eng_done, and reset during WAIT.
module tb_jacobi_buf_ctrl;

  localparam int AW = 7;
  localparam int DW = 20;
  localparam int MS = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          if_select;
  logic          mem_en_a, mem_we_a;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_din_a;
  logic [DW-1:0] mem_dout_a = '0;
  logic          eng_start, eng_done;
  logic [AW:0]   eng_len;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          busy, ovf;
`ifdef JACOBI_BUF_CTRL_PERF_CNT_EN
  logic [31:0]   eng_cycles;
`endif

  int checks = 0;
  int errors = 0;
  bit ovf_model = 1'b0;

  jacobi_buf_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .if_select (if_select),
    .mem_en_a  (mem_en_a),
    .mem_we_a  (mem_we_a),
    .mem_addr_a(mem_addr_a),
    .mem_din_a (mem_din_a),
    .mem_dout_a(mem_dout_a),
    .eng_start (eng_start),
    .eng_len   (eng_len),
    .eng_done  (eng_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf)
`ifdef JACOBI_BUF_CTRL_PERF_CNT_EN
    ,
    .eng_cycles(eng_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural buffer, interface 0 port A: synchronous write, one-cycle read latency.
  logic [DW-1:0] ram [MS];
  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) ram[mem_addr_a] <= mem_din_a;
      else          mem_dout_a      <= ram[mem_addr_a];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            reps;
    logic          iv, il;
    logic [DW-1:0] id;
    logic          done, ordy;
    logic          e_irdy, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_sel, e_start;
    logic [AW:0]   e_len;
    logic          e_ov, e_ol;
    logic [DW-1:0] e_od;
    logic          e_busy;
  } vec_t;

  vec_t vecs [14];

  task automatic run_frame(input int n, input logic [DW-1:0] base, input bit use_last,
                           input int done_delay, input bit toggle, input bit done_in_unload);
    int acc = (n > MS) ? MS : n;
    int rx = 0, issued = 0, max_out = 0, cyc = 0, hold_bad = 0, load_bad = 0;
    bit stall = 1'b0, sel_bad = 1'b0, done_ok = 1'b0;
    logic [DW-1:0] hold = '0;
    for (int k = 0; k < acc; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = base + DW'(k);
      in_last  = use_last && (k == n - 1);
      eng_done = 1'b0;
      #1;
      if (!in_ready || !mem_we_a || mem_addr_a !== AW'(k)) load_bad++;
    end
    check("load_handshakes", load_bad, 0);
    @(negedge clk);
    in_valid = (n > acc);
    in_data  = base + DW'(acc);
    in_last  = 1'b0;
    #1;
    check("start_pulse", eng_start, 1);
    check("start_if_select", if_select, 1);
    check("start_in_ready", in_ready, 0);
    check("start_eng_len", eng_len, acc);
    if (n > acc) ovf_model = 1'b1;
    for (int d = 1; d <= done_delay; d++) begin
      @(negedge clk);
      in_valid = (n > acc) && (d == 1);
      eng_done = (d == done_delay);
      #1;
      if (d == 1) begin
        check("wait_if_select", if_select, 1);
        check("wait_start_low", eng_start, 0);
        check("wait_mem_en", mem_en_a, 0);
        check("wait_ovf", ovf, ovf_model);
        if (n > acc) check("ovf_blocked", in_ready, 0);
      end
    end
    while (!done_ok && cyc < 4 * acc + 20) begin
      @(negedge clk);
      in_valid  = 1'b0;
      eng_done  = done_in_unload && (cyc == 2);
      out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (stall && (!out_valid || out_data !== hold)) hold_bad++;
      if (if_select !== 1'b0) sel_bad = 1'b1;
      if (mem_en_a && !mem_we_a) issued++;
      if (issued - rx > max_out) max_out = issued - rx;
      if (out_valid && out_ready) begin
        check("unload_data", out_data, base + DW'(rx));
        check("unload_last", out_last, rx == acc - 1);
        if (out_last) done_ok = 1'b1;
        rx++;
      end
      stall = out_valid && !out_ready;
      hold  = out_data;
      cyc++;
    end
    check("unload_complete", done_ok, 1);
    check("unload_count", rx, acc);
    check("unload_reads", issued, acc);
    check("unload_max_outstanding_le2", max_out <= 2, 1);
    check("unload_stall_hold", hold_bad, 0);
    check("unload_if_select", sel_bad, 0);
    @(negedge clk);
    out_ready = 1'b0;
    eng_done  = 1'b0;
    #1;
    check("back_busy", busy, 0);
    check("back_in_ready", in_ready, 1);
    check("back_out_valid", out_valid, 0);
    check("back_ovf", ovf, ovf_model);
`ifdef JACOBI_BUF_CTRL_PERF_CNT_EN
    check("eng_cycles", eng_cycles, done_delay);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //          reps iv il id        dn ordy irdy en we addr din      sel st len ov ol od       busy
    vecs[0]  = '{1,  0, 0, 20'h0,    0, 0,   1,   0, 0, 7'd0, 20'h0,  0,  0, 8'd0, 0, 0, 20'h0, 0};
    vecs[1]  = '{1,  1, 0, 20'h1,    0, 0,   1,   1, 1, 7'd0, 20'h1,  0,  0, 8'd0, 0, 0, 20'h0, 0};
    vecs[2]  = '{1,  1, 0, 20'h2,    0, 0,   1,   1, 1, 7'd1, 20'h2,  0,  0, 8'd0, 0, 0, 20'h0, 1};
    vecs[3]  = '{1,  1, 0, 20'h3,    0, 0,   1,   1, 1, 7'd2, 20'h3,  0,  0, 8'd0, 0, 0, 20'h0, 1};
    vecs[4]  = '{1,  1, 1, 20'h4,    0, 0,   1,   1, 1, 7'd3, 20'h4,  0,  0, 8'd0, 0, 0, 20'h0, 1};
    vecs[5]  = '{1,  0, 0, 20'h0,    0, 0,   0,   0, 0, 7'd0, 20'h0,  1,  1, 8'd4, 0, 0, 20'h0, 1};
    vecs[6]  = '{9,  0, 0, 20'h0,    0, 0,   0,   0, 0, 7'd0, 20'h0,  1,  0, 8'd4, 0, 0, 20'h0, 1};
    vecs[7]  = '{1,  0, 0, 20'h0,    1, 0,   0,   0, 0, 7'd0, 20'h0,  1,  0, 8'd4, 0, 0, 20'h0, 1};
    vecs[8]  = '{1,  0, 0, 20'h0,    0, 1,   0,   1, 0, 7'd0, 20'h0,  0,  0, 8'd4, 0, 0, 20'h0, 1};
    vecs[9]  = '{1,  0, 0, 20'h0,    0, 1,   0,   1, 0, 7'd1, 20'h0,  0,  0, 8'd4, 1, 0, 20'h1, 1};
    vecs[10] = '{1,  0, 0, 20'h0,    0, 1,   0,   1, 0, 7'd2, 20'h0,  0,  0, 8'd4, 1, 0, 20'h2, 1};
    vecs[11] = '{1,  0, 0, 20'h0,    0, 1,   0,   1, 0, 7'd3, 20'h0,  0,  0, 8'd4, 1, 0, 20'h3, 1};
    vecs[12] = '{1,  0, 0, 20'h0,    0, 1,   0,   0, 0, 7'd0, 20'h0,  0,  0, 8'd4, 1, 1, 20'h4, 1};
    vecs[13] = '{1,  0, 0, 20'h0,    0, 1,   1,   0, 0, 7'd0, 20'h0,  0,  0, 8'd4, 0, 0, 20'h0, 0};

    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    eng_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_if_select", if_select, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_len", eng_len, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_mem", {mem_en_a, mem_we_a, mem_addr_a, mem_din_a}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(negedge clk);
        in_valid  = vecs[i].iv;
        in_last   = vecs[i].il;
        in_data   = vecs[i].id;
        eng_done  = vecs[i].done;
        out_ready = vecs[i].ordy;
        #1;
        check($sformatf("v%0d.in_ready", i), in_ready, vecs[i].e_irdy);
        check($sformatf("v%0d.mem_en", i), mem_en_a, vecs[i].e_en);
        check($sformatf("v%0d.mem_we", i), mem_we_a, vecs[i].e_we);
        check($sformatf("v%0d.mem_addr", i), mem_addr_a, vecs[i].e_addr);
        check($sformatf("v%0d.mem_din", i), mem_din_a, vecs[i].e_din);
        check($sformatf("v%0d.if_select", i), if_select, vecs[i].e_sel);
        check($sformatf("v%0d.eng_start", i), eng_start, vecs[i].e_start);
        check($sformatf("v%0d.eng_len", i), eng_len, vecs[i].e_len);
        check($sformatf("v%0d.out_valid", i), out_valid, vecs[i].e_ov);
        check($sformatf("v%0d.out_last", i), out_last, vecs[i].e_ol);
        check($sformatf("v%0d.out_data", i), out_data, vecs[i].e_od);
        check($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
      end
    end
    check("frame1_ovf", ovf, 0);

    // eng_done while idle in LOAD must change nothing.
    @(negedge clk);
    out_ready = 1'b0;
    eng_done  = 1'b1;
    #1;
    check("done_in_load_busy", busy, 0);
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("done_in_load_if_select", if_select, 0);
    check("done_in_load_in_ready", in_ready, 1);
    check("done_in_load_no_start", eng_start, 0);

    // 8-word frame, out_ready pattern 1,0,0,1, stray eng_done during UNLOAD.
    run_frame(8, 20'h00100, 1'b1, 6, 1'b1, 1'b1);

    // 130 words without in_last: truncated at 128, ovf set.
    run_frame(130, 20'h00200, 1'b0, 3, 1'b0, 1'b0);

    // Reset asserted during WAIT.
    @(negedge clk);
    in_valid = 1'b1; in_data = 20'h12345; in_last = 1'b0;
    @(negedge clk);
    in_data = 20'h12346; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_wait_if_select", if_select, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_if_select", if_select, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_eng_len", eng_len, 0);
`ifdef JACOBI_BUF_CTRL_PERF_CNT_EN
    check("mid_rst_eng_cycles", eng_cycles, 0);
`endif
    ovf_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    run_frame(2, 20'hAAAAA, 1'b1, 4, 1'b0, 1'b0);

    // Engine takes 25 cycles after eng_start.
    run_frame(3, 20'h00300, 1'b1, 25, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jacobi_buf_ctrl.md
# jacobi_buf_ctrl

Sequencing controller for one dual-interface matrix buffer in the Jacobi datapath. It loads a matrix from an input stream through interface 0 and hands the buffer to the rotation engine by setting `if_select`. It waits for the engine to finish, then streams the result back out through interface 0. Memory-side outputs connect to interface 0 port A of the buffer; interface 0 port B is unused (tie off); interface 1 belongs to the engine.

## Interface
- `ADDR_WIDTH`, 7, buffer address width
- `MEM_SIZE`, 128, buffer depth in words (≤ 2^ADDR_WIDTH)
- `DATA_WIDTH`, 20, word width
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid` / `in_ready` / `in_data` / `in_last`  in/out/in/in  1/1/DATA_WIDTH/1  load stream; `in_last` marks final word
- `if_select`  out  1  buffer interface select: 0 = this block, 1 = engine
- `mem_en_a` / `mem_we_a`  out  1/1  interface 0 port A enable, write enable
- `mem_addr_a`  out  ADDR_WIDTH  port A address
- `mem_din_a`  out  DATA_WIDTH  port A write data
- `mem_dout_a`  in  DATA_WIDTH  port A read data, valid 1 cycle after read enable
- `eng_start`  out  1  one-cycle engine start pulse
- `eng_len`  out  ADDR_WIDTH+1  number of valid words, stable from `eng_start` until UNLOAD ends
- `eng_done`  in  1  engine completion pulse
- `out_valid` / `out_ready` / `out_data` / `out_last`  out/in/out/out  1/1/DATA_WIDTH/1  unload stream
- `busy`  out  1  high in every state except LOAD with zero words loaded
- `ovf`  out  1  sticky: frame truncated at MEM_SIZE; cleared only by reset

## Operation
- States: LOAD → START → WAIT → UNLOAD → LOAD.
- LOAD (`if_select`=0)
  - `in_ready`=1.
  - On `in_valid & in_ready`: combinationally drive `mem_en_a`=`mem_we_a`=1, `mem_addr_a`=`wr_cnt`, `mem_din_a`=`in_data`; then `wr_cnt`++.
  - Exit on a handshake with `in_last`, or on the MEM_SIZE-th word. In the MEM_SIZE case without `in_last`, set `ovf`; later words stay blocked (`in_ready`=0) until the next LOAD.
  - Latch `len` = words written (1..MEM_SIZE).
- START
  - `if_select` register goes 1 on entry.
  - `eng_start`=1 for exactly this one cycle, then WAIT.
- WAIT
  - `if_select`=1; all `mem_*` outputs 0.
  - On `eng_done`: `if_select`←0, go to UNLOAD.
  - `eng_done` is ignored in every other state.
- UNLOAD (`if_select`=0)
  - Issue reads at addresses 0..len-1 via `mem_en_a`=1, `mem_we_a`=0.
  - Read data enters a 2-entry output FIFO.
  - Issue a read only when (FIFO occupancy + reads in flight) < 2. This sustains 1 word/cycle under continuous `out_ready`.
  - `out_last`=1 with word len-1.
  - After the `out_last` handshake: clear `wr_cnt` and the read counters, go to LOAD.
- `out_valid` is never withdrawn before its handshake. `out_data` is stable while `out_valid & !out_ready`.

## Timing
- Reset values:
  - state=LOAD, `if_select`=0, `in_ready`=0 during reset (1 from the first cycle after release).
  - `eng_start`=0, `eng_len`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `ovf`=0, all `mem_*`=0.
- Reset mid-operation aborts the frame immediately. Buffer contents are undefined afterwards; the engine must also be reset.
- Cycle after the final load handshake: START (`if_select`=1, `eng_start`=1). Next cycle: WAIT.
- `eng_done` seen at edge N: `if_select`=0 from cycle N+1; first read issued in cycle N+1; `out_valid` earliest at N+2.
- Minimum frame turnaround, excluding engine time and with `out_ready` held high: len load cycles + 1 (START) + 1 + len unload cycles.
- `out_ready` low: at most 2 words buffered; no reads are issued while full.

## Configuration
- `JACOBI_BUF_CTRL_PERF_CNT_EN` defined:
  - Adds output `eng_cycles` (32 bits).
  - Counts cycles spent in WAIT, saturating at 2^32-1.
  - Clears at START; holds its value through UNLOAD and LOAD; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `jacobi_pkg`: state enum `buf_ctrl_state_t` (LOAD, START, WAIT, UNLOAD), default `ADDR_WIDTH`/`DATA_WIDTH`/`MEM_SIZE` constants.
- One sub-module: `rd_skid_fifo`, a 2-entry valid/ready FIFO parameterised by `DATA_WIDTH`, carrying {`last`, `data`}.

## Test plan
- Load 4 words 0x00001..0x00004, `in_last` on the 4th → `eng_start` pulse 1 cycle later, `eng_len`=4, `if_select`=1; `eng_done` after 10 cycles → out stream 0x00001..0x00004, `out_last` on 0x00004, `ovf`=0.
- Load 130 words with no `in_last` (MEM_SIZE=128) → `in_ready` drops after word 128, `ovf`=1, `eng_len`=128, unload emits 128 words.
- Unload 8 words with `out_ready` toggling 1,0,0,1 → no data lost or duplicated, `out_data` stable while stalled, never more than 2 reads outstanding.
- `eng_done` pulsed during LOAD and during UNLOAD → ignored; state and `if_select` unchanged.
- Assert `rst` during WAIT → `if_select`=0 and `out_valid`=0 immediately; `in_ready`=1 the cycle after release; a fresh 2-word frame then completes correctly.
- With `JACOBI_BUF_CTRL_PERF_CNT_EN` defined: `eng_done` 25 cycles after `eng_start` → `eng_cycles`=25.
